// File: rtl/line_segment_feeder_if.sv
// Segment upload port: valid/ready handshake carrying both endpoints of one line segment.
interface line_segment_feeder_if;
  logic        seg_valid_in;
  logic        seg_ready_out;
  logic [10:0] seg_x1_in;
  logic [9:0]  seg_y1_in;
  logic [10:0] seg_x2_in;
  logic [9:0]  seg_y2_in;

  modport master (
    output seg_valid_in, seg_x1_in, seg_y1_in, seg_x2_in, seg_y2_in,
    input  seg_ready_out
  );

  modport slave (
    input  seg_valid_in, seg_x1_in, seg_y1_in, seg_x2_in, seg_y2_in,
    output seg_ready_out
  );
endinterface

// File: rtl/line_segment_feeder.sv
// Buffers segments in a FIFO and pops/normalises one at frame start; results appear 1 cycle later.
// Upstream is stalled only by a full FIFO (ready = !full); the renderer side never backpressures.
module line_segment_feeder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_FRAMES = 1,
  parameter int H_MAX       = 1279,
  parameter int V_MAX       = 719
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [10:0]                   hcount_in,
  input  logic [9:0]                    vcount_in,
  line_segment_feeder_if.slave          seg,
  output logic [10:0]                   x1_out,
  output logic [9:0]                    y1_out,
  output logic [10:0]                   x2_out,
  output logic [9:0]                    y2_out,
  output logic                          line_rst_out,
  output logic                          line_active_out,
  output logic                          reject_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [10:0] HMAX_L = 11'(H_MAX);
  localparam logic [9:0]  VMAX_L = 10'(V_MAX);

  typedef struct packed {
    logic [10:0] x1;
    logic [9:0]  y1;
    logic [10:0] x2;
    logic [9:0]  y2;
  } seg_t;

  seg_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [10:0] x1_q, x1_d, x2_q, x2_d;
  logic [9:0]  y1_q, y1_d, y2_q, y2_d;
  logic        rst_q, rst_d, active_q, active_d, reject_q, reject_d;

  logic        frame_start, push, pop, ready, drawable;
  seg_t        head, sw;
  logic [10:0] nx1, nx2;
  logic [9:0]  ny1, ny2;
  logic signed [11:0] dx, dy;

  assign frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign ready       = (count_q != CW'(FIFO_DEPTH));
  assign push        = seg.seg_valid_in && ready;
  assign pop         = frame_start && (count_q != '0) && ((hold_q == '0) || !active_q);

  // Swap so x1 <= x2, then clamp; clamping is monotonic so the ordering survives.
  assign head = mem_q[rd_ptr_q];
  assign sw   = (head.x1 > head.x2) ? '{x1: head.x2, y1: head.y2, x2: head.x1, y2: head.y1} : head;
  assign nx1  = (sw.x1 > HMAX_L) ? HMAX_L : sw.x1;
  assign nx2  = (sw.x2 > HMAX_L) ? HMAX_L : sw.x2;
  assign ny1  = (sw.y1 > VMAX_L) ? VMAX_L : sw.y1;
  assign ny2  = (sw.y2 > VMAX_L) ? VMAX_L : sw.y2;
  assign dx   = $signed({1'b0, nx2}) - $signed({1'b0, nx1});
  assign dy   = $signed({2'b00, ny2}) - $signed({2'b00, ny1});
  assign drawable = (dy >= 12'sd0) && (dy <= dx);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_comb begin
    hold_d = hold_q;
    if (pop)                                hold_d = HW'(HOLD_FRAMES - 1);
    else if (frame_start && hold_q != '0)   hold_d = hold_q - HW'(1);
  end

  // Endpoints only move together with a restart pulse to the renderer.
  always_comb begin
    x1_d     = x1_q;
    y1_d     = y1_q;
    x2_d     = x2_q;
    y2_d     = y2_q;
    active_d = active_q;
    rst_d    = 1'b0;
    reject_d = 1'b0;
    if (pop) begin
      if (drawable) begin
        x1_d     = nx1;
        y1_d     = ny1;
        x2_d     = nx2;
        y2_d     = ny2;
        active_d = 1'b1;
        rst_d    = 1'b1;
      end else begin
        active_d = 1'b0;
        reject_d = 1'b1;
      end
    end else if (frame_start && active_q) begin
      rst_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= '{x1: seg.seg_x1_in, y1: seg.seg_y1_in,
                                   x2: seg.seg_x2_in, y2: seg.seg_y2_in};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      x2_q     <= '0;
      y2_q     <= '0;
      active_q <= 1'b0;
      reject_q <= 1'b0;
      rst_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      x2_q     <= x2_d;
      y2_q     <= y2_d;
      active_q <= active_d;
      reject_q <= reject_d;
      rst_q    <= rst_d;
    end
  end

  assign seg.seg_ready_out = ready;
  assign x1_out            = x1_q;
  assign y1_out            = y1_q;
  assign x2_out            = x2_q;
  assign y2_out            = y2_q;
  assign line_rst_out      = rst_q;
  assign line_active_out   = active_q;
  assign reject_out        = reject_q;
  assign fifo_count_out    = count_q;

endmodule
